// File: rtl/apu_pkg.sv
// Shared types and constants for the APU pulse sweep / period timer block.
package apu_pkg;

  typedef struct packed {
    logic       en;
    logic [2:0] div_p;
    logic       neg;
    logic [2:0] shift;
  } sweep_reg_t;

  localparam int PERIOD_MIN       = 8;
  localparam int PERIOD_W_DEFAULT = 11;

endpackage

// File: rtl/apu_sweep_channel.sv
// One pulse channel: period register, down-counting timer, sweep divider,
// sweep target computation and mute flag.
module apu_sweep_channel
  import apu_pkg::*;
#(
  parameter int PERIOD_W  = PERIOD_W_DEFAULT,
  parameter bit ONES_COMP = 1'b0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                apu_tick,
  input  logic                half_frame,
  input  logic                sweep_wr,
  input  logic                period_lo_wr,
  input  logic                period_hi_wr,
  input  logic [7:0]          wr_data,
  output logic                seq_clk,
  output logic                mute,
  output logic [PERIOD_W-1:0] period
);

  localparam logic [PERIOD_W-1:0] MIN_P = PERIOD_W'(PERIOD_MIN);

  logic [PERIOD_W-1:0] counter;
  logic [PERIOD_W-1:0] period_nxt;
  logic [PERIOD_W:0]   target;
  logic [2:0]          divider;
  logic                reload;
  logic                sweep_upd;
  sweep_reg_t          sweep;

  // Negative results only occur on paths that are muted anyway; clamp to zero.
  function automatic logic [PERIOD_W:0] calc_target(input logic [PERIOD_W-1:0] per,
                                                    input sweep_reg_t sw);
    logic signed [PERIOD_W+1:0] base;
    logic signed [PERIOD_W+1:0] delta;
    logic signed [PERIOD_W+1:0] diff;
    base  = $signed({2'b00, per});
    delta = $signed({2'b00, per >> sw.shift});
    if (!sw.neg) diff = base + delta;
    else         diff = base - delta - $signed({{(PERIOD_W+1){1'b0}}, ONES_COMP});
    if (diff < 0) calc_target = '0;
    else          calc_target = diff[PERIOD_W:0];
  endfunction

  assign target    = calc_target(period, sweep);
  assign mute      = (period < MIN_P) | (!sweep.neg & target[PERIOD_W]);
  assign sweep_upd = (divider == 3'd0) & sweep.en & (sweep.shift != 3'd0) & !mute;
  assign seq_clk   = apu_tick & (counter == '0);

  // CPU writes override only the bits they carry; the rest keep the sweep result.
  always_comb begin
    period_nxt = period;
    if (half_frame && sweep_upd) period_nxt = target[PERIOD_W-1:0];
    if (period_lo_wr) period_nxt[7:0] = wr_data;
    if (period_hi_wr) period_nxt[PERIOD_W-1:8] = wr_data[PERIOD_W-9:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period  <= '0;
      counter <= '0;
    end else begin
      period <= period_nxt;
      if (apu_tick) counter <= (counter == '0) ? period : counter - 1'b1;
    end
  end

  // A sweep write in the same cycle as a half-frame step lands last, so reload stays set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sweep   <= '0;
      divider <= '0;
      reload  <= 1'b0;
    end else begin
      if (half_frame) begin
        if (divider == 3'd0 || reload) begin
          divider <= sweep.div_p;
          reload  <= 1'b0;
        end else begin
          divider <= divider - 1'b1;
        end
      end
      if (sweep_wr) begin
        sweep  <= sweep_reg_t'(wr_data);
        reload <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/apu_sweep_ctrl.sv
// Multi-channel NES APU pulse sweep + period timer; one independent channel
// instance per pulse voice.
module apu_sweep_ctrl
  import apu_pkg::*;
#(
  parameter int                NUM_CH         = 2,
  parameter int                PERIOD_W       = PERIOD_W_DEFAULT,
  parameter logic [NUM_CH-1:0] ONES_COMP_MASK = 2'b01
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         apu_tick,
  input  logic                         half_frame,
  input  logic [NUM_CH-1:0]            sweep_wr,
  input  logic [NUM_CH-1:0]            period_lo_wr,
  input  logic [NUM_CH-1:0]            period_hi_wr,
  input  logic [7:0]                   wr_data,
  output logic [NUM_CH-1:0]            seq_clk,
  output logic [NUM_CH-1:0]            mute,
  output logic [NUM_CH*PERIOD_W-1:0]   period
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    apu_sweep_channel #(
      .PERIOD_W  (PERIOD_W),
      .ONES_COMP (ONES_COMP_MASK[i])
    ) u_ch (
      .clk          (clk),
      .reset_n      (reset_n),
      .apu_tick     (apu_tick),
      .half_frame   (half_frame),
      .sweep_wr     (sweep_wr[i]),
      .period_lo_wr (period_lo_wr[i]),
      .period_hi_wr (period_hi_wr[i]),
      .wr_data      (wr_data),
      .seq_clk      (seq_clk[i]),
      .mute         (mute[i]),
      .period       (period[i*PERIOD_W +: PERIOD_W])
    );
  end

endmodule
